// File: rtl/rec_sub_pipe.sv
// Three-stage pipelined 32-bit parallel-prefix subtractor (diff = a - b) with valid/ready flow control.
// Optional signed-overflow output ovf is enabled by defining REC_SUB_OVF_EN.
module rec_sub_pipe #(
  parameter int WIDTH = 32,
  parameter int LOGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
`ifdef REC_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             zero
);

  localparam int SPLIT = LOGW / 2;

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
  } kgp_t;

  // Kogge-Stone combine over levels [lo, hi); after all levels g[i] is the carry out of bit i.
  function automatic kgp_t prefix_levels(input kgp_t x, input int lo, input int hi);
    kgp_t y;
    kgp_t t;
    int   d;
    int   j;
    y = x;
    for (int lv = 0; lv < LOGW; lv++) begin
      if (lv >= lo && lv < hi) begin
        t = y;
        d = 1 << lv;
        for (int i = 0; i < WIDTH; i++) begin
          j = (i >= d) ? i - d : 0;
          if (i >= d) begin
            y.g[i] = t.g[i] | (t.p[i] & t.g[j]);
            y.p[i] = t.p[i] & t.p[j];
          end
        end
      end
    end
    return y;
  endfunction

  function automatic logic [WIDTH-1:0] prefix_carry(input kgp_t x, input int lo, input int hi);
    kgp_t y;
    y = prefix_levels(x, lo, hi);
    return y.g;
  endfunction

  logic             w_advance;
  logic             r1_valid;
  logic             r2_valid;
  logic             r3_valid;

  logic [WIDTH-1:0] r1_a;
  logic [WIDTH-1:0] r1_nb;
  kgp_t             r2_kgp;
  logic [WIDTH-1:0] r2_hs;

  kgp_t             w_kgp0;
  kgp_t             w_kgp_s2;
  logic [WIDTH-1:0] w_hs;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic             w_zero;

  logic [WIDTH-1:0] r3_diff;
  logic             r3_borrow;
  logic             r3_zero;

  // The whole pipe moves together; a held result freezes every stage behind it.
  assign w_advance = ~r3_valid | out_ready;
  assign in_ready  = w_advance;

  // Decode the registered (a, ~b) pairs into kill/generate/propagate; carry-in 1 turns bit-0 propagate into generate.
  always_comb begin
    w_hs      = r1_a ^ r1_nb;
    w_kgp0.g  = r1_a & r1_nb;
    w_kgp0.p  = w_hs;
    w_kgp0.g[0] = r1_a[0] | r1_nb[0];
    w_kgp0.p[0] = 1'b0;
  end

  assign w_kgp_s2 = prefix_levels(w_kgp0, 0, SPLIT);

  assign w_carry  = prefix_carry(r2_kgp, SPLIT, LOGW);
  assign w_diff   = r2_hs ^ {w_carry[WIDTH-2:0], 1'b1};
  assign w_borrow = ~w_carry[WIDTH-1];
  assign w_zero   = ~|w_diff;

  // NOTE: sequential state is always written with non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
      r3_valid <= 1'b0;
    end else if (w_advance) begin
      r1_valid <= in_valid;
      r2_valid <= r1_valid;
      r3_valid <= r2_valid;
    end
  end

  // NOTE: internal operand/KGP registers carry no reset; their valid bits alone decide whether they mean anything.
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r1_a   <= a;
      r1_nb  <= ~b;
      r2_kgp <= w_kgp_s2;
      r2_hs  <= w_hs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r3_diff   <= '0;
      r3_borrow <= 1'b0;
      r3_zero   <= 1'b0;
    end else if (w_advance) begin
      r3_diff   <= w_diff;
      r3_borrow <= w_borrow;
      r3_zero   <= w_zero;
    end
  end

`ifdef REC_SUB_OVF_EN
  logic r2_a_msb;
  logic r2_b_msb;
  logic r3_ovf;

  always_ff @(posedge clk) begin
    if (w_advance) begin
      r2_a_msb <= r1_a[WIDTH-1];
      r2_b_msb <= ~r1_nb[WIDTH-1];
    end
  end

  // Signed overflow: operand signs differ and the result sign departs from the minuend's.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r3_ovf <= 1'b0;
    end else if (w_advance) begin
      r3_ovf <= (r2_a_msb ^ r2_b_msb) & (w_diff[WIDTH-1] ^ r2_a_msb);
    end
  end

  assign ovf = r3_ovf;
`endif

  assign out_valid = r3_valid;
  assign diff      = r3_diff;
  assign borrow    = r3_borrow;
  assign zero      = r3_zero;

endmodule

// File: tb/tb_rec_sub_pipe.sv
// Directed self-checking bench for rec_sub_pipe: latency, streaming, backpressure, async reset and optional ovf.
module tb_rec_sub_pipe;

  localparam int W = 32;

  logic         clk       = 1'b0;
  logic         reset     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;
`ifdef REC_SUB_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  rec_sub_pipe #(.WIDTH(W), .LOGW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
`ifdef REC_SUB_OVF_EN
    .ovf       (ovf),
`endif
    .zero      (zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        br;
    logic        z;
    logic        ov;
  } vec_t;

  vec_t vecs[13];
  int   exp_q[$];
  int   cur_idx  = 0;
  bit   last_acc = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int k, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] vd, input logic vbr, input logic vz, input logic vov);
    vecs[k].a  = va;
    vecs[k].b  = vb;
    vecs[k].d  = vd;
    vecs[k].br = vbr;
    vecs[k].z  = vz;
    vecs[k].ov = vov;
  endtask

  task automatic drive(input int k);
    a        = vecs[k].a;
    b        = vecs[k].b;
    cur_idx  = k;
    in_valid = 1'b1;
  endtask

  // Called at a falling edge with inputs settled: scores any transfer and any acceptance at the coming rising edge.
  task automatic tick();
    int k;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {31'b0, out_valid}, 32'd0);
      end else begin
        k = exp_q.pop_front();
        check($sformatf("diff[%0d]", k), diff, vecs[k].d);
        check($sformatf("borrow[%0d]", k), {31'b0, borrow}, {31'b0, vecs[k].br});
        check($sformatf("zero[%0d]", k), {31'b0, zero}, {31'b0, vecs[k].z});
`ifdef REC_SUB_OVF_EN
        check($sformatf("ovf[%0d]", k), {31'b0, ovf}, {31'b0, vecs[k].ov});
`endif
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) exp_q.push_back(cur_idx);
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget, output int used);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    used      = 0;
    while (exp_q.size() > 0 && used < budget) begin
      tick();
      used++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    set_vec(0,  32'd5,        32'd3,        32'h00000002, 1'b0, 1'b0, 1'b0);
    set_vec(1,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    set_vec(2,  32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b1, 1'b0);
    set_vec(3,  32'd0,        32'd1,        32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    set_vec(4,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0);
    set_vec(5,  32'h12345678, 32'h00000078, 32'h12345600, 1'b0, 1'b0, 1'b0);
    set_vec(6,  32'd1,        32'd0,        32'h00000001, 1'b0, 1'b0, 1'b0);
    set_vec(7,  32'd100,      32'd1,        32'h00000063, 1'b0, 1'b0, 1'b0);
    set_vec(8,  32'd7,        32'd7,        32'h00000000, 1'b0, 1'b1, 1'b0);
    set_vec(9,  32'h10,       32'h20,       32'hFFFFFFF0, 1'b1, 1'b0, 1'b0);
    set_vec(10, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    set_vec(11, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
    set_vec(12, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b1);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_diff", diff, 32'd0);
    check("rst_borrow", {31'b0, borrow}, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    reset     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // Single op latency: result valid on the third edge after acceptance
    drive(0);
    tick();
    in_valid = 1'b0;
    check("lat_edge1", {31'b0, out_valid}, 32'd0);
    tick();
    check("lat_edge2", {31'b0, out_valid}, 32'd0);
    tick();
    check("lat_edge3", {31'b0, out_valid}, 32'd1);
    drain("lat_drain", 5, n);

    // Borrow case and equal operands
    drive(1);
    tick();
    drive(2);
    tick();
    drain("eq_drain", 10, n);

    // Back-to-back streaming at full rate
    for (int k = 3; k <= 6; k++) begin
      drive(k);
      check("stream_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
    end
    drain("stream_drain", 10, n);
    check("stream_drain_cycles", 32'(n), 32'd3);

    // Backpressure: three ops inside, fourth waiting at the input, consumer stalled for five cycles
    out_ready = 1'b0;
    drive(7);
    tick();
    drive(8);
    tick();
    drive(9);
    tick();
    drive(10);
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_diff_hold", diff, vecs[7].d);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_accept", {31'b0, last_acc}, 32'd1);
    drain("bp_drain", 10, n);
    check("bp_drain_cycles", 32'(n), 32'd3);
    for (int c = 0; c < 3; c++) begin
      check("bp_no_dup", {31'b0, out_valid}, 32'd0);
      tick();
    end

    // Asynchronous reset with two ops in flight
    drive(5);
    tick();
    drive(6);
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_diff", diff, 32'd0);
    check("async_rst_zero", {31'b0, zero}, 32'd0);
`ifdef REC_SUB_OVF_EN
    check("async_rst_ovf", {31'b0, ovf}, 32'd0);
`endif
    exp_q.delete();
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check("post_rst_idle", {31'b0, out_valid}, 32'd0);
      tick();
    end

    // Signed-overflow vectors (diff/borrow always scored, ovf when present)
    drive(11);
    tick();
    drive(12);
    tick();
    drive(0);
    tick();
    drain("ovf_drain", 10, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
